// File: rtl/swervolf_uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud divisor helper.
package swervolf_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Rounded clocks-per-bit
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 32'd2) / baud;
    endfunction

endpackage

// File: rtl/swervolf_uart_rx_fifo.sv
// First-word-fall-through byte FIFO with level counter; head is visible while non-empty.
module swervolf_uart_rx_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned DW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [DW-1:0]      data_i,
    input  logic               pop_i,
    output logic [DW-1:0]      data_o,
    output logic               valid_o,
    output logic               full_o,
    output logic [FIFO_AW:0]   level_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]    mem_q [DEPTH];
    logic [FIFO_AW:0] wr_q, wr_d;
    logic [FIFO_AW:0] rd_q, rd_d;
    logic [FIFO_AW:0] level_s;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer arithmetic, push/pop qualification
    always_comb begin
        level_s   = wr_q - rd_q;
        empty_s   = (level_s == {(FIFO_AW+1){1'b0}});
        full_s    = (level_s == DEPTH_L);
        do_pop_s  = pop_i & ~empty_s;
        // A pop frees the slot, so a push to a full FIFO succeeds in the same cycle
        do_push_s = push_i & (~full_s | do_pop_s);
        wr_d      = do_push_s ? (wr_q + {{FIFO_AW{1'b0}}, 1'b1}) : wr_q;
        rd_d      = do_pop_s  ? (rd_q + {{FIFO_AW{1'b0}}, 1'b1}) : rd_q;
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= {(FIFO_AW+1){1'b0}};
            rd_q <= {(FIFO_AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_q[FIFO_AW-1:0]] <= data_i;
        end else begin
            mem_q[wr_q[FIFO_AW-1:0]] <= mem_q[wr_q[FIFO_AW-1:0]];
        end
    end

    assign data_o  = mem_q[rd_q[FIFO_AW-1:0]];
    assign valid_o = ~empty_s;
    assign full_o  = full_s;
    assign level_o = level_s;

endmodule

// File: rtl/swervolf_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, byte FIFO and error/overflow flags.
module swervolf_uart_rx
    import swervolf_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_AW     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_uart_rx,
    output logic [7:0]         o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_frame_err,
    output logic               o_overflow,
    input  logic               i_clr_overflow,
    output logic [FIFO_AW:0]   o_fifo_level
);

    localparam int unsigned DIV  = baud_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    generate
        if (DIV < 8) begin : g_div_check
            $error("swervolf_uart_rx: baud divisor below 8");
        end
    endgenerate

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q;
    logic            overflow_q, overflow_d;
    logic            fall_s, cnt_zero_s, push_s, ferr_s, pop_s, full_s;

    // Two-flop synchronizer plus edge-detect history; idle-high reset avoids a false edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_s     = prev_q & ~sync2_q;
    assign cnt_zero_s = (cnt_q == {CW{1'b0}});

    // Frame FSM next-state, bit counter and shift register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end else if (!sync2_q) begin
                    state_d = DATA;
                    cnt_d   = DIV_M1;
                    bit_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = DIV_M1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    // Leaving at mid-stop-bit lets a zero-gap next start edge be seen
                    state_d = IDLE;
                    if (sync2_q) begin
                        push_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign pop_s = i_ready & o_valid;

    // Sticky overflow; a new drop outranks a clear in the same cycle
    always_comb begin
        if (push_s & full_s & ~pop_s) begin
            overflow_d = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Status flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= ferr_s;
            overflow_q  <= overflow_d;
        end
    end

    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;

    swervolf_uart_rx_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (shift_q),
        .pop_i   (pop_s),
        .data_o  (o_data),
        .valid_o (o_valid),
        .full_o  (full_s),
        .level_o (o_fifo_level)
    );

endmodule
